// File: rtl/apb_master.sv
// apb_master: single-outstanding APB requester with a valid/ready command port and wait-state timeout
module apb_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR       = 5,
  parameter int TIMEOUT    = 16
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR-1:0]       cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR-1:0]       paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic                  pready,
  input  logic                  pslverr,
  input  logic [DATA_WIDTH-1:0] prdata
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR-1:0]       paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  timeout, done, accept;
  assign timeout   = (TIMEOUT > 0) && !pready && (cnt_q == CW'(TIMEOUT));
  assign done      = (state_q == ACCESS) && (pready || timeout);
  // gating with presetn keeps cmd_ready low while reset is held
  assign cmd_ready = presetn && ((state_q == IDLE) || done);
  assign accept    = cmd_valid && cmd_ready;
  always_comb begin
    state_d     = accept ? SETUP : (state_q == SETUP) ? ACCESS : done ? IDLE : state_q;
    cnt_d       = (state_q == SETUP) ? '0 :
                  ((state_q == ACCESS) && !pready && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
    pwrite_d    = accept ? cmd_write : pwrite_q;
    paddr_d     = accept ? cmd_addr : paddr_q;
    pwdata_d    = accept ? cmd_wdata : pwdata_q;
    rsp_valid_d = done;
    rsp_err_d   = done && (timeout || pslverr);
    rsp_rdata_d = (done && pready && !pwrite_q) ? prdata : '0;
  end
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end
  assign psel      = state_q != IDLE;
  assign penable   = state_q == ACCESS;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: scoreboard bench with a behavioural APB slave driven from per-transfer configs
module tb_apb_master;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int TO = 4;
  logic pclk = 1'b0;
  logic presetn = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic rsp_valid, rsp_err, psel, penable, pwrite;
  logic [DW-1:0] rsp_rdata, pwdata;
  logic [AW-1:0] paddr;
  logic pready = 1'b0, pslverr = 1'b0;
  logic [DW-1:0] prdata = '0;
  apb_master #(.DATA_WIDTH(DW), .ADDR(AW), .TIMEOUT(TO)) dut (
    .pclk(pclk), .presetn(presetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pready(pready), .pslverr(pslverr), .prdata(prdata)
  );
  always #5 pclk = ~pclk;
  typedef struct {
    logic w; logic [AW-1:0] a; logic [DW-1:0] d; int waits; logic err; logic [DW-1:0] rd; logic b2b;
  } cfg_t;
  typedef struct {
    logic [DW-1:0] rd; logic err; int lat; int acc;
  } exp_t;
  cfg_t cfg_q[$];
  exp_t exp_q[$];
  cfg_t cur;
  exp_t m_e;
  int scnt, cyc, rsp_cnt, errors, checks;
  logic prev_psel, prev_pen;
  initial begin
    cyc = 0; rsp_cnt = 0; errors = 0; checks = 0; scnt = 0;
    prev_psel = 1'b0; prev_pen = 1'b0;
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(posedge pclk) cyc <= cyc + 1;
  // response monitor and slave model share one negedge process so ordering is fixed
  always @(negedge pclk) begin
    if (rsp_valid) begin
      rsp_cnt++;
      if (exp_q.size() == 0) chk("rsp_spurious", rsp_valid, 0);
      else begin
        m_e = exp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, m_e.rd);
        chk("rsp_err", rsp_err, m_e.err);
        chk("rsp_lat", cyc - m_e.acc, m_e.lat);
      end
    end
    if (!presetn) begin
      pready = 1'b0; pslverr = 1'b0; prev_psel = 1'b0; prev_pen = 1'b0;
    end else begin
      if (penable && !psel) chk("psel_pen", psel, 1);
      if (psel && !penable) begin
        if (cfg_q.size() == 0) chk("setup_nocfg", psel, 0);
        else begin
          cur = cfg_q.pop_front();
          scnt = 0;
          chk("b2b_gap", {prev_psel, prev_pen}, cur.b2b ? 2'b11 : 2'b00);
          chk("setup_paddr", paddr, cur.a);
          chk("setup_pwrite", pwrite, cur.w);
          if (cur.w) chk("setup_pwdata", pwdata, cur.d);
        end
        pready = 1'b0; pslverr = 1'b0; prdata = $urandom;
      end else if (psel && penable) begin
        chk("hold_addr", {pwrite, paddr}, {cur.w, cur.a});
        if (cur.w) chk("hold_wdata", pwdata, cur.d);
        if (scnt == cur.waits) begin
          pready = 1'b1; pslverr = cur.err; prdata = cur.rd;
        end else begin
          pready = 1'b0; pslverr = 1'($urandom); prdata = $urandom; scnt++;
        end
      end else begin
        pready = 1'b0; pslverr = 1'b0; prdata = $urandom;
      end
      prev_psel = psel; prev_pen = penable;
    end
  end
  // call away from the rising edge; returns 1ns after the accepting edge
  task automatic do_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int waits, input logic err, input logic [DW-1:0] rd, input logic b2b);
    cfg_t c;
    exp_t e;
    bit ok, to;
    ok = 0;
    to = waits > TO;
    c = '{w, a, d, waits, err, rd, b2b};
    cfg_q.push_back(c);
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready) begin
        @(posedge pclk); #1;
        ok = 1;
        break;
      end
      @(negedge pclk); #2;
    end
    cmd_valid = 1'b0;
    chk("accept", ok, 1);
    if (ok) begin
      e.rd = (to || w) ? '0 : rd;
      e.err = to ? 1'b1 : err;
      e.lat = 2 + (to ? TO : waits);
      e.acc = cyc;
      exp_q.push_back(e);
    end
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 100 && (exp_q.size() + cfg_q.size()) != 0; i++) begin
      @(negedge pclk); #1;
    end
    chk("drain", exp_q.size() + cfg_q.size(), 0);
  endtask
  initial begin
    int rel, r0;
    #3;
    chk("rst_apb", {psel, penable, pwrite, paddr, pwdata}, 0);
    chk("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
    chk("rst_ready", cmd_ready, 0);
    @(negedge pclk); #2;
    presetn = 1'b1;
    #1;
    chk("ready_after_rst", cmd_ready, 1);
    rel = cyc;
    do_cmd(1'b1, 5'h03, 32'hDEADBEEF, 0, 1'b0, 32'h0, 1'b0);
    chk("first_accept_edge", cyc - rel, 1);
    wait_idle();
    do_cmd(1'b0, 5'h05, 32'h0, 2, 1'b0, 32'h12345678, 1'b0);
    wait_idle();
    do_cmd(1'b0, 5'h1F, 32'h0, 1, 1'b1, 32'hBADC0DE5, 1'b0);
    wait_idle();
    do_cmd(1'b0, 5'h0A, 32'h0, 99, 1'b0, 32'h55AA55AA, 1'b0);
    wait_idle();
    chk("timeout_idle", {psel, penable, cmd_ready}, 3'b001);
    do_cmd(1'b1, 5'h11, 32'hA5A5A5A5, 0, 1'b0, 32'h0, 1'b0);
    do_cmd(1'b1, 5'h12, 32'h5A5A5A5A, 0, 1'b0, 32'h0, 1'b1);
    wait_idle();
    do_cmd(1'b0, 5'h07, 32'h0, 99, 1'b0, 32'h1, 1'b0);
    @(negedge pclk);
    @(negedge pclk); #1;
    presetn = 1'b0;
    #1;
    chk("rst_mid_apb", {psel, penable}, 2'b00);
    chk("rst_mid_rsp", {rsp_valid, cmd_ready}, 2'b00);
    exp_q.delete();
    cfg_q.delete();
    r0 = rsp_cnt;
    repeat (2) @(negedge pclk);
    #2 presetn = 1'b1;
    repeat (6) @(negedge pclk);
    #1;
    chk("rst_no_rsp", rsp_cnt - r0, 0);
    do_cmd(1'b1, 5'h09, 32'hCAFEF00D, 1, 1'b0, 32'h0, 1'b0);
    wait_idle();
    for (int i = 0; i < 4; i++) begin
      do_cmd(1'($urandom), 5'($urandom), $urandom, $urandom_range(0, 3), 1'($urandom_range(0, 3) == 0), $urandom, 1'b0);
      do_cmd(1'($urandom), 5'($urandom), $urandom, $urandom_range(0, 3), 1'($urandom_range(0, 3) == 0), $urandom, 1'b1);
      wait_idle();
    end
    repeat (3) @(negedge pclk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
